// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads over a variable-latency
// handshake, holds each instruction until decode accepts it, then picks the next PC.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [ADDR_WIDTH-1:0] pc,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  input  logic                  branch_en,
  input  logic [7:0]            branch_disp
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  rd_en_q, rd_en_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [ADDR_WIDTH-1:0] disp_ext;

  assign disp_ext = {{(ADDR_WIDTH-8){branch_disp[7]}}, branch_disp};

  // Redirect inputs are only consulted through next_pc, which is only taken on the handshake.
  always_comb begin
    if (jump_en)
      next_pc = jump_addr;
    else if (branch_en)
      next_pc = pc_q + disp_ext;
    else
      next_pc = pc_q + ADDR_WIDTH'(1);
  end

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rd_en_d = rd_en_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      FETCH: begin
        // rd_en low in FETCH only happens in the startup cycle after reset; any response then is stale.
        if (!rd_en_q) begin
          rd_en_d = 1'b1;
        end else if (mem_rd_valid) begin
          instr_d = mem_rd_data;
          valid_d = 1'b1;
          rd_en_d = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          rd_en_d = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_ADDR;
      rd_en_q <= 1'b0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rd_en_q <= rd_en_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign mem_rd_en   = rd_en_q;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: next-PC vector table plus startup, stall and reset sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_rd_data;
  logic        mem_rd_valid;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] pc;
  logic        jump_en;
  logic [15:0] jump_addr;
  logic        branch_en;
  logic [7:0]  branch_disp;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] cur_pc;

  typedef struct {
    logic [15:0] start_pc;
    logic        j;
    logic [15:0] ja;
    logic        b;
    logic [7:0]  disp;
    logic [15:0] exp_next;
  } vec_t;

  vec_t vecs[8];

  fetch_unit #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RESET_ADDR(16'h0000)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_rd_valid(mem_rd_valid),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .branch_en   (branch_en),
    .branch_disp (branch_disp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_en"}, mem_rd_en, 0);
    check({tag, "_addr"}, mem_addr, 16'h0000);
    check({tag, "_pc"}, pc, 16'h0000);
    check({tag, "_instr"}, instr, 16'h0000);
    check({tag, "_valid"}, instr_valid, 0);
  endtask

  // Wait for the read request, keep the memory busy for lat cycles, then return data.
  task automatic do_fetch(input int lat, input logic [15:0] data, input bit noise);
    int n = 0;
    while (mem_rd_en !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("rd_en_rise", mem_rd_en, 1);
    check("fetch_addr", mem_addr, cur_pc);
    for (int i = 0; i < lat; i++) begin
      if (noise) begin
        jump_en = 1'b1; branch_en = 1'b1; jump_addr = 16'hDEAD; branch_disp = 8'h40;
        instr_ready = 1'b1;
      end
      tick();
      check("addr_stable", mem_addr, cur_pc);
      check("rd_en_stable", mem_rd_en, 1);
    end
    jump_en = 1'b0; branch_en = 1'b0; jump_addr = 'x; branch_disp = 'x; instr_ready = 1'b0;
    mem_rd_valid = 1'b1; mem_rd_data = data;
    tick();
    mem_rd_valid = 1'b0; mem_rd_data = 'x;
    check("cap_valid", instr_valid, 1);
    check("cap_instr", instr, data);
    check("cap_rd_en", mem_rd_en, 0);
    check("cap_pc", pc, cur_pc);
  endtask

  // Stall in HOLD with a stray jump pulse, then complete the handshake with the given redirect.
  task automatic handshake(input int stall, input logic [15:0] held, input bit j, input logic [15:0] ja,
                           input bit b, input logic [7:0] d, input logic [15:0] exp_next);
    for (int i = 0; i < stall; i++) begin
      instr_ready = 1'b0; jump_en = 1'b1; jump_addr = 16'hBEEF;
      tick();
      check("hold_valid", instr_valid, 1);
      check("hold_instr", instr, held);
      check("hold_pc", pc, cur_pc);
      check("hold_rd_en", mem_rd_en, 0);
    end
    instr_ready = 1'b1; jump_en = j; jump_addr = ja; branch_en = b; branch_disp = d;
    tick();
    instr_ready = 1'b0; jump_en = 1'b0; branch_en = 1'b0; jump_addr = 'x; branch_disp = 'x;
    check("hs_valid", instr_valid, 0);
    check("hs_rd_en", mem_rd_en, 1);
    check("hs_addr", mem_addr, exp_next);
    check("hs_pc", pc, exp_next);
    cur_pc = exp_next;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{16'h0010, 1'b0, 16'h0000, 1'b1, 8'hFC, 16'h000C};
    vecs[1] = '{16'h0010, 1'b0, 16'h0000, 1'b1, 8'h7F, 16'h008F};
    vecs[2] = '{16'h0010, 1'b1, 16'h1234, 1'b1, 8'h05, 16'h1234};
    vecs[3] = '{16'hFFFF, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000};
    vecs[4] = '{16'h0000, 1'b0, 16'h0000, 1'b1, 8'hFF, 16'hFFFF};
    vecs[5] = '{16'h0100, 1'b0, 16'h0000, 1'b1, 8'h80, 16'h0080};
    vecs[6] = '{16'h0005, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0006};
    vecs[7] = '{16'h0005, 1'b1, 16'h0000, 1'b0, 8'h00, 16'h0000};

    reset_n = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = 'x; instr_ready = 1'b0;
    jump_en = 1'b0; jump_addr = 'x; branch_en = 1'b0; branch_disp = 'x;
    cur_pc = 16'h0000;

    // Reset and one-cycle startup.
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    reset_n = 1'b1;
    tick();
    check("startup_rd_en", mem_rd_en, 1);
    check("startup_addr", mem_addr, 16'h0000);
    do_fetch(1, 16'h5123, 1'b0);
    handshake(0, 16'h5123, 1'b0, 16'h0, 1'b0, 8'h0, 16'h0001);

    // Sequential fetches with 3-cycle memory latency and 4-cycle decode stall.
    for (int a = 1; a < 4; a++) begin
      logic [15:0] d;
      d = 16'hA000 + 16'(a);
      do_fetch(3, d, a == 2);
      handshake(4, d, 1'b0, 16'h0, 1'b0, 8'h0, cur_pc + 16'h1);
    end
    check("seq_end_addr", mem_addr, 16'h0004);

    // Next-PC vectors: jump to the start pc, fetch there, then apply the vector on the handshake.
    for (int i = 0; i < 8; i++) begin
      do_fetch(1, 16'h1000 + 16'(i), 1'b0);
      handshake(0, 16'h1000 + 16'(i), 1'b1, vecs[i].start_pc, 1'b0, 8'h0, vecs[i].start_pc);
      do_fetch(2, 16'h2000 + 16'(i), 1'b0);
      handshake(1, 16'h2000 + 16'(i), vecs[i].j, vecs[i].ja, vecs[i].b, vecs[i].disp, vecs[i].exp_next);
    end

    // Reset while a read is outstanding; a response during and right after reset must be dropped.
    tick();
    tick();
    check("pre_rst_rd_en", mem_rd_en, 1);
    reset_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    mem_rd_valid = 1'b1; mem_rd_data = 16'hAAAA;
    tick();
    tick();
    check("rst_valid_ignored", instr_valid, 0);
    check("rst_rd_en_low", mem_rd_en, 0);
    reset_n = 1'b1;
    tick();
    check("restart_rd_en", mem_rd_en, 1);
    check("restart_addr", mem_addr, 16'h0000);
    check("restart_valid_ignored", instr_valid, 0);
    mem_rd_valid = 1'b0; mem_rd_data = 'x;
    cur_pc = 16'h0000;
    do_fetch(2, 16'h7777, 1'b0);
    handshake(2, 16'h7777, 1'b0, 16'h0, 1'b0, 8'h0, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
